// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and constants for the banked-memory request sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

endpackage

// File: rtl/mem_bank_sequencer_if.sv
// mem_bank_sequencer_if: request, response and bank-array signals of the sequencer.
// slave = the sequencer itself, master = the request source / bank environment.
interface mem_bank_sequencer_if #(
    parameter int unsigned NUM_MEMS      = 8,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned ADDR_SIZE     = 6,
    parameter int unsigned BANK_SEL_SIZE = 3
);

    logic                      req_valid;
    logic                      req_ready;
    logic [BANK_SEL_SIZE-1:0]  req_bank;
    logic [ADDR_SIZE-1:0]      req_addr;
    logic                      req_wr_rd;
    logic [WIDTH-1:0]          req_wdata;

    logic [ADDR_SIZE-1:0]      mem_addr;
    logic                      mem_wr_rd;
    logic [NUM_MEMS*WIDTH-1:0] mem_wdata;
    logic [NUM_MEMS*WIDTH-1:0] mem_rdata;
    logic [NUM_MEMS-1:0]       mem_valid;
    logic [NUM_MEMS-1:0]       mem_ready;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [WIDTH-1:0]          rsp_rdata;
    logic                      rsp_wr_rd;
    logic                      rsp_err;

    modport slave (
        input  req_valid, req_bank, req_addr, req_wr_rd, req_wdata,
        input  mem_rdata, mem_ready, rsp_ready,
        output req_ready, mem_addr, mem_wr_rd, mem_wdata, mem_valid,
        output rsp_valid, rsp_rdata, rsp_wr_rd, rsp_err
    );

    modport master (
        output req_valid, req_bank, req_addr, req_wr_rd, req_wdata,
        output mem_rdata, mem_ready, rsp_ready,
        input  req_ready, mem_addr, mem_wr_rd, mem_wdata, mem_valid,
        input  rsp_valid, rsp_rdata, rsp_wr_rd, rsp_err
    );

endinterface

// File: rtl/mem_seq_timer.sv
// mem_seq_timer: bank-response timeout counter; compiled only with MEM_SEQ_TIMEOUT_EN.
// expired_c fires in the ISSUE cycle that would bring the count to TIMEOUT_CYCLES.
`ifdef MEM_SEQ_TIMEOUT_EN
module mem_seq_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    assign expired_c = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count waiting cycles; parks on expiry since the FSM leaves ISSUE then.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/mem_bank_sequencer.sv
// mem_bank_sequencer: accepts one single-bank request at a time, drives the bank
// array, waits for the selected bank and returns one response per request.
// Optional bank-response timeout: define MEM_SEQ_TIMEOUT_EN.
module mem_bank_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned NUM_MEMS       = 8,
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned ADDR_SIZE      = 6,
    parameter int unsigned BANK_SEL_SIZE  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_bank_sequencer_if.slave bus
);

    state_t                    state;
    logic [BANK_SEL_SIZE-1:0]  bank_q;

    logic                      accept_c;
    logic                      bank_ok_c;
    logic                      sel_ready_c;
    logic [WIDTH-1:0]          sel_rdata_c;
    logic [NUM_MEMS-1:0]       onehot_c;
    logic [NUM_MEMS*WIDTH-1:0] wdata_c;
    logic                      timeout_c;

    assign accept_c  = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign bank_ok_c = 32'(bus.req_bank) < NUM_MEMS;

    // Decode the incoming request into a bank strobe and slice-aligned write data.
    always_comb begin
        onehot_c = '0;
        wdata_c  = '0;
        for (int i = 0; i < int'(NUM_MEMS); i++) begin
            if (bus.req_bank == BANK_SEL_SIZE'(i)) begin
                onehot_c[i] = 1'b1;
                if (bus.req_wr_rd == WR) begin
                    wdata_c[i*WIDTH +: WIDTH] = bus.req_wdata;
                end
            end
        end
    end

    // Pick the latched bank's ready and read-data slice; other banks are ignored.
    always_comb begin
        sel_ready_c = 1'b0;
        sel_rdata_c = '0;
        for (int i = 0; i < int'(NUM_MEMS); i++) begin
            if (bank_q == BANK_SEL_SIZE'(i)) begin
                sel_ready_c = bus.mem_ready[i];
                sel_rdata_c = bus.mem_rdata[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MEM_SEQ_TIMEOUT_EN
    logic timer_clear_c;
    logic timer_en_c;

    assign timer_clear_c = accept_c && bank_ok_c;
    assign timer_en_c    = (state == ISSUE) && !sel_ready_c;

    mem_seq_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear_c),
        .enable    (timer_en_c),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Parameter sanity, checked while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (DEPTH > 0 && TIMEOUT_CYCLES > 0 &&
                    (64'(1) << BANK_SEL_SIZE) >= 64'(NUM_MEMS));
        end
    end

    // Sequencer FSM with registered request, bank and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bank_q        <= '0;
            bus.req_ready <= 1'b0;
            bus.mem_valid <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wr_rd <= 1'b0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_wr_rd <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept_c) begin
                        bus.req_ready <= 1'b0;
                        bank_q        <= bus.req_bank;
                        bus.rsp_wr_rd <= bus.req_wr_rd;
                        if (bank_ok_c) begin
                            state         <= ISSUE;
                            bus.mem_valid <= onehot_c;
                            bus.mem_addr  <= bus.req_addr;
                            bus.mem_wr_rd <= bus.req_wr_rd;
                            bus.mem_wdata <= wdata_c;
                        end else begin
                            state         <= ERR;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (sel_ready_c) begin
                        state         <= RESP;
                        bus.mem_valid <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= (bus.mem_wr_rd == RD) ? sel_rdata_c : '0;
                    end else if (timeout_c) begin
                        state         <= ERR;
                        bus.mem_valid <= '0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                    end
                end
                RESP, ERR: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bank_sequencer.md
Name: mem_bank_sequencer

Overview:
- Upstream request sequencer for the banked memory wrapper (NUM_MEMS independent banks sharing addr/wr_rd, per-bank valid/ready, concatenated wdata/rdata).
- Accepts one single-bank request at a time on a valid/ready port, drives the bank array, waits for the selected bank's ready, and returns a response on a valid/ready response port.
- Serialises accesses: at most one outstanding bank transaction.

Parameters:
- NUM_MEMS, 8, number of banks; width of mem_valid/mem_ready.
- DEPTH, 64, words per bank; informational, not checked.
- WIDTH, 8, data bits per bank.
- ADDR_SIZE, 6, word-address bits per bank.
- BANK_SEL_SIZE, 3, bank-select bits; must satisfy 2**BANK_SEL_SIZE >= NUM_MEMS.
- TIMEOUT_CYCLES, 255, maximum wait for mem_ready; used only with the optional feature.

Ports:
- clk  in  1  clock; everything is synchronous to the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_bank  in  BANK_SEL_SIZE  target bank index.
- req_addr  in  ADDR_SIZE  word address.
- req_wr_rd  in  1  1=write, 0=read.
- req_wdata  in  WIDTH  write data.
- mem_addr  out  ADDR_SIZE  shared bank address.
- mem_wr_rd  out  1  shared write/read strobe.
- mem_wdata  out  NUM_MEMS*WIDTH  bank i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
- mem_rdata  in  NUM_MEMS*WIDTH  same slicing as mem_wdata.
- mem_valid  out  NUM_MEMS  one-hot bank strobe.
- mem_ready  in  NUM_MEMS  per-bank completion.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  WIDTH  read data; 0 for writes and errors.
- rsp_wr_rd  out  1  echo of the request type.
- rsp_err  out  1  bad bank index, or timeout.

Behaviour:
- Bank contract: a bank completes in the first cycle where mem_valid[i]=1 and mem_ready[i]=1. Read data on that bank's mem_rdata slice is valid in that same cycle.
- States:
  - IDLE: req_ready=1; all mem_valid=0; rsp_valid=0.
  - ISSUE: exactly one mem_valid bit=1; mem_addr, mem_wr_rd and mem_wdata held stable.
  - ERR: rsp_valid=1, rsp_err=1; no bank access.
  - RESP: rsp_valid=1, rsp_err=0.
- Transitions:
  - IDLE → ISSUE on req_valid && req_ready with req_bank < NUM_MEMS. Address, type, bank and data are registered.
  - IDLE → ERR on req_valid && req_ready with req_bank >= NUM_MEMS.
  - ISSUE → RESP on mem_ready[bank]. On the read path, rsp_rdata captures that bank's slice in this cycle. mem_valid deasserts in the following cycle.
  - RESP or ERR → IDLE on rsp_ready.
- Outputs in ISSUE/RESP/ERR: req_ready=0.
- Latency: request accepted at cycle T; mem_valid high at T+1. Bank ready first seen at cycle T+1+k (k>=0). rsp_valid high at T+2+k. With rsp_ready held high, the next request can be accepted at T+3+k.
- Write data: mem_wdata carries the write data in the selected bank's slice only; all other slices are 0. For reads, mem_wdata is all 0.
- Unselected-bank inputs: mem_ready bits of unselected banks are ignored. mem_rdata slices of unselected banks are ignored.
- Response hold: the response stays stable while rsp_valid && !rsp_ready.
- Reset values: req_ready=0 during rst, then 1 in IDLE; mem_valid=0; mem_addr=0; mem_wr_rd=0; mem_wdata=0; rsp_valid=0; rsp_rdata=0; rsp_wr_rd=0; rsp_err=0; state=IDLE.
- Reset mid-operation: mem_valid drops on the cycle after rst is sampled. Any pending response is discarded, with no rsp_valid.
- mem_ready arriving in the same cycle as mem_valid first rises gives k=0; this is legal.

Optional Feature:
- Macro: MEM_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle without the selected bank's mem_ready.
  - When the count reaches TIMEOUT_CYCLES: mem_valid drops, and the next state is ERR (rsp_err=1, rsp_rdata=0).
  - mem_ready arriving in the same cycle as expiry wins: normal completion.
- Not defined: no counter; ISSUE waits indefinitely, and rsp_err arises only from a bad bank index.

Decomposition:
- Package mem_seq_pkg:
  - state enum {IDLE, ISSUE, RESP, ERR};
  - constants WR=1'b1, RD=1'b0.
- Sub-module mem_seq_timer: the timeout counter (clear, enable, expired). It is instantiated only under MEM_SEQ_TIMEOUT_EN.

Test Plan:
- Write then read, both with k=2: write bank 3, addr 5, data 0xA5; mem_valid=8'b0000_1000; mem_wdata[31:24]=0xA5 and all other bits 0; rsp for the write has rdata=0 and err=0. Read the same location with the bank model returning 0xA5 → rsp_rdata=0xA5 at T+4.
- Zero-wait read: bank 0 read with mem_ready[0] already high → rsp_valid at T+2; a stray mem_ready on bank 5 throughout has no effect.
- Bad bank: NUM_MEMS=6, req_bank=7 → no mem_valid; rsp_err=1 at T+1.
- Backpressure: rsp_ready held low for 5 cycles → rsp fields stable; req_ready=0 throughout; second request accepted the cycle after rsp_ready rises.
- Reset mid-ISSUE: rst asserted while waiting → mem_valid=0 and rsp_valid=0 the next cycle; a later mem_ready is ignored.
- Timeout (MEM_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4): bank never ready → mem_valid drops after 4 ISSUE cycles; rsp_err=1 with rdata=0.
